vga_tile_decoder: RTL and testbench

Receive-side decoder for the 640x480 tile-palette VGA screen. It watches the 12-bit RGB output and the active-low hsync/vsync of the screen path, rebuilds pixel coordinates from the sync edges, and samples the center of each of the 12 palette tiles once per frame. From those samples it reports which tile is drawn highlighted, recovering `color_id` from the video signal. It sits beside the screen path on the system clock and serves as a loopback checker on hardware and as a scoreboard in simulation.

---
 rtl/vga_tile_decoder.sv | 173 +++++++++++++++++
 tb/tb_vga_tile_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_decoder.sv
// Loopback decoder for the tile-palette VGA screen: rebuilds pixel coordinates
// from the sync edges and recovers the highlighted tile index once per frame.
module vga_tile_decoder #(
    parameter int H_OFFSET = 48,
    parameter int V_OFFSET = 34,
    parameter int H_TOTAL  = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [3:0] vgaRed,
    input  logic [3:0] vgaGreen,
    input  logic [3:0] vgaBlue,
    output logic [3:0] color_id_out,
    output logic       id_valid,
    output logic       tile_err,
    output logic       frame_done,
    output logic       sync_lost
);

    typedef enum logic [1:0] {HUNT, ACTIVE, DONE} state_t;

    // Tile k occupies bits [12k +: 12].
    localparam logic [143:0] HL_CODES = {12'hCAE, 12'hAAE, 12'hAAF, 12'hACF, 12'hADF, 12'h9FF,
                                         12'h9DC, 12'h8C8, 12'hDEA, 12'hFE9, 12'hEB8, 12'hF98};
    localparam logic [143:0] NM_CODES = {12'h83C, 12'h42B, 12'h34E, 12'h37F, 12'h3BE, 12'h3ED,
                                         12'h2B8, 12'h392, 12'hAF2, 12'hFE2, 12'hF83, 12'hE10};

    localparam logic [9:0] CNT_MAX = '1;
    localparam logic [9:0] HC_WDOG = 10'(H_TOTAL + 16);
    localparam logic [9:0] VC_END  = 10'(V_OFFSET + 480);
    localparam logic [9:0] HC_C0   = 10'(H_OFFSET + 140);
    localparam logic [9:0] HC_C1   = 10'(H_OFFSET + 260);
    localparam logic [9:0] HC_C2   = 10'(H_OFFSET + 380);
    localparam logic [9:0] HC_C3   = 10'(H_OFFSET + 500);
    localparam logic [9:0] VC_R0   = 10'(V_OFFSET + 120);
    localparam logic [9:0] VC_R1   = 10'(V_OFFSET + 240);
    localparam logic [9:0] VC_R2   = 10'(V_OFFSET + 360);

    state_t      r_state;
    logic        r_hs, r_vs;
    logic [9:0]  r_hc, r_vc;
    logic [11:0] r_hit, r_bad;
    logic        r_end, r_smp_vld, r_smp_hl, r_smp_nm;
    logic [3:0]  r_smp_idx;

    logic        w_hs_rise, w_vs_rise, w_col_ok, w_row_ok;
    logic [9:0]  w_hc_nxt, w_vc_nxt;
    logic [1:0]  w_col, w_row;
    logic [3:0]  w_idx, w_hit_cnt, w_hit_idx;
    logic [11:0] w_pix, w_hl_code, w_nm_code;

    assign w_hs_rise = pix_en & hsync & ~r_hs;
    assign w_vs_rise = pix_en & vsync & ~r_vs;
    assign w_pix     = {vgaRed, vgaGreen, vgaBlue};

    // Counter values that belong to the pixel presented on this strobe.
    assign w_hc_nxt = w_hs_rise ? '0 : ((r_hc == CNT_MAX) ? CNT_MAX : r_hc + 10'd1);
    assign w_vc_nxt = w_vs_rise ? '0 :
                      ((w_hs_rise && r_vc != CNT_MAX) ? r_vc + 10'd1 : r_vc);

    always_comb begin
        w_col_ok = 1'b1;
        w_col    = '0;
        case (w_hc_nxt)
            HC_C0:   w_col = 2'd0;
            HC_C1:   w_col = 2'd1;
            HC_C2:   w_col = 2'd2;
            HC_C3:   w_col = 2'd3;
            default: w_col_ok = 1'b0;
        endcase
        w_row_ok = 1'b1;
        w_row    = '0;
        case (w_vc_nxt)
            VC_R0:   w_row = 2'd0;
            VC_R1:   w_row = 2'd1;
            VC_R2:   w_row = 2'd2;
            default: w_row_ok = 1'b0;
        endcase
    end

    assign w_idx     = {w_row, w_col};
    assign w_hl_code = HL_CODES[12*int'(w_idx) +: 12];
    assign w_nm_code = NM_CODES[12*int'(w_idx) +: 12];

    always_comb begin
        w_hit_cnt = '0;
        w_hit_idx = '0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (r_hit[k]) begin
                w_hit_cnt = w_hit_cnt + 4'd1;
                w_hit_idx = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= HUNT;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_hc         <= '0;
            r_vc         <= '0;
            r_hit        <= '0;
            r_bad        <= '0;
            r_end        <= 1'b0;
            r_smp_vld    <= 1'b0;
            r_smp_hl     <= 1'b0;
            r_smp_nm     <= 1'b0;
            r_smp_idx    <= '0;
            color_id_out <= 4'hF;
            id_valid     <= 1'b0;
            tile_err     <= 1'b0;
            frame_done   <= 1'b0;
            sync_lost    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Sample/end events are staged one clk before they touch flags or state.
            r_end      <= w_hs_rise & ~w_vs_rise & (w_vc_nxt == VC_END);
            r_smp_vld  <= pix_en & (r_state == ACTIVE) & w_col_ok & w_row_ok;
            r_smp_idx  <= w_idx;
            r_smp_hl   <= (w_pix == w_hl_code);
            r_smp_nm   <= (w_pix == w_nm_code);

            if (pix_en) begin
                r_hs <= hsync;
                r_vs <= vsync;
                r_hc <= w_hc_nxt;
                r_vc <= w_vc_nxt;
            end

            if (r_smp_vld) begin
                if (r_smp_hl)
                    r_hit[r_smp_idx] <= 1'b1;
                else if (!r_smp_nm)
                    r_bad[r_smp_idx] <= 1'b1;
            end

            case (r_state)
                HUNT: ;
                ACTIVE: if (r_end) r_state <= DONE;
                DONE: begin
                    if (w_hit_cnt == 4'd1) begin
                        color_id_out <= w_hit_idx;
                        id_valid     <= 1'b1;
                    end else begin
                        color_id_out <= (w_hit_cnt == 4'd0) ? 4'hF : 4'hE;
                        id_valid     <= 1'b0;
                    end
                    tile_err   <= |r_bad;
                    frame_done <= 1'b1;
                    r_state    <= HUNT;
                end
                default: r_state <= HUNT;
            endcase

            if (pix_en && w_hc_nxt == HC_WDOG) begin
                sync_lost <= 1'b1;
                r_state   <= HUNT;
            end

            if (w_vs_rise) begin
                r_state   <= ACTIVE;
                r_hit     <= '0;
                r_bad     <= '0;
                sync_lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_decoder.sv
// Randomized bench for vga_tile_decoder: compressed-timing frames (only sampled
// lines are full length) checked against a tile-classification model.
module tb_vga_tile_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_en = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [3:0] vgaRed = '0, vgaGreen = '0, vgaBlue = '0;
    logic [3:0] color_id_out;
    logic       id_valid, tile_err, frame_done, sync_lost;

    vga_tile_decoder #(.H_OFFSET(48), .V_OFFSET(34), .H_TOTAL(800)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .hsync        (hsync),
        .vsync        (vsync),
        .vgaRed       (vgaRed),
        .vgaGreen     (vgaGreen),
        .vgaBlue      (vgaBlue),
        .color_id_out (color_id_out),
        .id_valid     (id_valid),
        .tile_err     (tile_err),
        .frame_done   (frame_done),
        .sync_lost    (sync_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] HL [12] = '{12'hF98, 12'hEB8, 12'hFE9, 12'hDEA, 12'h8C8, 12'h9DC,
                             12'h9FF, 12'hADF, 12'hACF, 12'hAAF, 12'hAAE, 12'hCAE};
    logic [11:0] NM [12] = '{12'hE10, 12'hF83, 12'hFE2, 12'hAF2, 12'h392, 12'h2B8,
                             12'h3ED, 12'h3BE, 12'h37F, 12'h34E, 12'h42B, 12'h83C};
    logic [11:0] ctr [12];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_id   = 15;
    int exp_cyc  = 0;
    int n_done   = 0;
    bit exp_valid = 1'b0, exp_err = 1'b0, exp_sl = 1'b0;
    bit exp_pending = 1'b0, armed = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rnd();
        return 12'($urandom);
    endfunction

    always @(negedge clk) begin
        if (rst && frame_done) begin
            n_done++;
            if (exp_pending) begin
                check_eq("done_latency", cyc, exp_cyc);
                check_eq("color_id", int'(color_id_out), exp_id);
                check_eq("id_valid", int'(id_valid), int'(exp_valid));
                check_eq("tile_err", int'(tile_err), int'(exp_err));
                exp_pending = 1'b0;
            end else begin
                check_eq("spurious_frame_done", int'(frame_done), 0);
            end
        end
    end

    // Called at posedge+1; the pixel is sampled on the next posedge.
    task automatic pix(input logic hs, input logic vs, input logic [11:0] rgb);
        pix_en = 1'b1;
        hsync  = hs;
        vsync  = vs;
        {vgaRed, vgaGreen, vgaBlue} = rgb;
        @(posedge clk); #1;
        if ($urandom_range(3) == 0) begin
            pix_en = 1'b0;
            hsync  = 1'($urandom);
            vsync  = 1'($urandom);
            {vgaRed, vgaGreen, vgaBlue} = rnd();
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        pix_en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_center(input int cid);
        for (int k = 0; k < 12; k++) ctr[k] = (k == cid) ? HL[k] : NM[k];
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_color_id"}, int'(color_id_out), 15);
        check_eq({tag, "_id_valid"}, int'(id_valid), 0);
        check_eq({tag, "_tile_err"}, int'(tile_err), 0);
        check_eq({tag, "_frame_done"}, int'(frame_done), 0);
        check_eq({tag, "_sync_lost"}, int'(sync_lost), 0);
    endtask

    task automatic run_frame(input bit stuck, input bit rmid, input bit sim, input bit decoy);
        int cols [4] = '{140, 260, 380, 500};
        int rows [3] = '{120, 240, 360};
        int hits, hidx, y, rr, rn, x, done0;
        bit bad;
        logic [11:0] v;

        check_eq("hold_color_id", int'(color_id_out), exp_id);
        check_eq("hold_id_valid", int'(id_valid), int'(exp_valid));
        check_eq("hold_tile_err", int'(tile_err), int'(exp_err));
        done0 = n_done;

        pix(1'b1, 1'b0, rnd());
        pix(1'b1, 1'b0, rnd());
        if (sim) begin
            pix(1'b0, 1'b0, rnd());
            pix(1'b1, 1'b1, rnd());
        end else begin
            pix(1'b1, 1'b1, rnd());
        end
        armed  = 1'b1;
        exp_sl = 1'b0;
        check_eq("sync_lost_after_vsync", int'(sync_lost), 0);

        for (int n = 1; n <= 514; n++) begin
            y = n - 34;
            pix(1'b0, 1'b1, rnd());
            if (n == 514 && armed) begin
                hits = 0; hidx = 0; bad = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    if (ctr[k] == HL[k]) begin
                        hits++;
                        hidx = k;
                    end else if (ctr[k] != NM[k]) begin
                        bad = 1'b1;
                    end
                end
                exp_id      = (hits == 1) ? hidx : ((hits == 0) ? 15 : 14);
                exp_valid   = (hits == 1);
                exp_err     = bad;
                exp_cyc     = cyc + 3;
                exp_pending = 1'b1;
            end
            pix(1'b1, 1'b1, rnd());

            rr = -1; rn = -1;
            for (int r = 0; r < 3; r++) begin
                if (y == rows[r]) rr = r;
                if (decoy && (y == rows[r] - 1 || y == rows[r] + 1)) rn = r;
            end
            if (rr >= 0 || rn >= 0) begin
                for (int j = 1; j <= 560; j++) begin
                    x = j - 48;
                    v = rnd();
                    for (int c = 0; c < 4; c++) begin
                        if (x == cols[c]) v = (rr >= 0) ? ctr[4*rr+c] : HL[4*rn+c];
                        else if (decoy && rr >= 0 && (x == cols[c] - 1 || x == cols[c] + 1))
                            v = HL[4*rr+c];
                    end
                    pix(1'b1, 1'b1, v);
                end
            end

            if (stuck && n == 150) begin
                repeat (900) pix(1'b1, 1'b1, rnd());
                armed  = 1'b0;
                exp_sl = 1'b1;
                check_eq("sync_lost_set", int'(sync_lost), 1);
            end
            if (rmid && n == 234) begin
                pix_en = 1'b0;
                rst    = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                armed     = 1'b0;
                exp_id    = 15;
                exp_valid = 1'b0;
                exp_err   = 1'b0;
                check_reset_outputs("midrst");
            end
        end

        repeat (3) pix(1'b1, 1'b1, rnd());
        idle(3);
        check_eq("frame_done_count", n_done - done0, armed ? 1 : 0);
        check_eq("sync_lost_end", int'(sync_lost), int'(exp_sl));
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // No vsync rise yet: a full line count must not complete a frame.
        for (int n = 0; n < 520; n++) begin
            pix(1'b0, 1'b1, rnd());
            pix(1'b1, 1'b1, rnd());
        end
        idle(3);
        check_eq("hunt_no_done", n_done, 0);

        set_center(5);  run_frame(1'b0, 1'b0, 1'b0, 1'b1);
        set_center(5);  run_frame(1'b0, 1'b0, 1'b1, 1'b0);
        set_center(12); run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        set_center(0);  ctr[3] = 12'h000; run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        set_center(2);  ctr[7] = 12'hADF; run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        set_center(4);  run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        set_center(9);  run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        set_center(6);  run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        set_center(11); run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            set_center(int'($urandom_range(12)));
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(5) == 0) begin
                    case ($urandom_range(2))
                        0:       ctr[k] = rnd();
                        1:       ctr[k] = HL[k];
                        default: ctr[k] = NM[k];
                    endcase
                end
            end
            run_frame(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end

        check_eq("frame_done_missing", int'(exp_pending), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
